// File: rtl/pc_gen.sv
// pc_gen: RV32I fetch-address generator.
// Produces the instruction-memory fetch address. The next PC is chosen from the
// trap vector, an execute-stage redirect, a stall hold, a return-address-stack
// pop, or the sequential PC+4.
//
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-low reset
//   i_stall             hold the current PC
//   i_redirect/_tgt     execute-stage redirect and its target address
//   i_trap              exception/interrupt, vectors to TRAP_VEC
//   i_call / i_ret      predecoded call/return at the current o_pc
//   o_pc, o_pc_valid    fetch address and its validity
//   o_misaligned        one-cycle pulse for a misaligned redirect target
//   o_bad_addr          the last misaligned target seen
//   o_ras_empty/_full   return-address-stack occupancy flags
module pc_gen #(
  parameter int unsigned      WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VEC = 32'h0000_0000,
  parameter logic [WIDTH-1:0] TRAP_VEC  = 32'h0000_0100,
  parameter int unsigned      RAS_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_stall,
  input  logic             i_redirect,
  input  logic [WIDTH-1:0] i_redirect_tgt,
  input  logic             i_trap,
  input  logic             i_call,
  input  logic             i_ret,
  output logic [WIDTH-1:0] o_pc,
  output logic             o_pc_valid,
  output logic             o_misaligned,
  output logic [WIDTH-1:0] o_bad_addr,
  output logic             o_ras_empty,
  output logic             o_ras_full
);

  localparam int unsigned      PW       = $clog2(RAS_DEPTH);
  localparam int unsigned      CW       = $clog2(RAS_DEPTH + 1);
  localparam logic [CW-1:0]    FULL_CNT = CW'(RAS_DEPTH);

  logic [WIDTH-1:0] pc_q, pc_d;
  logic             valid_q;
  logic             mis_q, mis_d;
  logic [WIDTH-1:0] bad_q, bad_d;
  logic [PW-1:0]    ptr_q, ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] ras_q [RAS_DEPTH];
  logic [WIDTH-1:0] ras_d [RAS_DEPTH];

  logic [WIDTH-1:0] pc_inc;
  logic [PW-1:0]    top_idx;

  // ptr_q addresses the next free slot; the top entry is at ptr_q-1. Because
  // the pointer wraps over a power-of-two array, a push into a full stack
  // lands on the oldest entry, which gives overwrite-on-overflow for free.
  always_comb begin
    pc_inc  = pc_q + WIDTH'(4);
    top_idx = ptr_q - PW'(1);
    pc_d    = pc_q;
    mis_d   = 1'b0;
    bad_d   = bad_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    ras_d   = ras_q;

    if (i_trap) begin
      pc_d  = TRAP_VEC;
      cnt_d = '0;
      ptr_d = '0;
    end else if (i_redirect && (i_redirect_tgt[1:0] != 2'b00)) begin
      pc_d  = TRAP_VEC;
      mis_d = 1'b1;
      bad_d = i_redirect_tgt;
      cnt_d = '0;
      ptr_d = '0;
    end else if (i_redirect) begin
      pc_d = i_redirect_tgt;
    end else if (i_stall) begin
      pc_d = pc_q;
    end else begin
      pc_d = pc_inc;
      if (i_ret && (cnt_q != '0)) begin
        pc_d = ras_q[top_idx];
        if (i_call) begin
          // Pop and push in one cycle: reuse the vacated top slot.
          ras_d[top_idx] = pc_inc;
        end else begin
          ptr_d = top_idx;
          cnt_d = cnt_q - CW'(1);
        end
      end else if (i_call) begin
        ras_d[ptr_q] = pc_inc;
        ptr_d        = ptr_q + PW'(1);
        if (cnt_q != FULL_CNT) cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q    <= RESET_VEC;
      valid_q <= 1'b0;
      mis_q   <= 1'b0;
      bad_q   <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      ras_q   <= '{default: '0};
    end else begin
      pc_q    <= pc_d;
      valid_q <= 1'b1;
      mis_q   <= mis_d;
      bad_q   <= bad_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      ras_q   <= ras_d;
    end
  end

  assign o_pc         = pc_q;
  assign o_pc_valid   = valid_q;
  assign o_misaligned = mis_q;
  assign o_bad_addr   = bad_q;
  assign o_ras_empty  = (cnt_q == '0);
  assign o_ras_full   = (cnt_q == FULL_CNT);

endmodule

// File: tb/tb_pc_gen.sv
module tb_pc_gen;

  localparam logic [31:0] TRAP  = 32'h0000_0100;
  localparam int          DEPTH = 4;

  logic        clk;
  logic        rst;
  logic        i_stall;
  logic        i_redirect;
  logic [31:0] i_redirect_tgt;
  logic        i_trap;
  logic        i_call;
  logic        i_ret;
  logic [31:0] o_pc;
  logic        o_pc_valid;
  logic        o_misaligned;
  logic [31:0] o_bad_addr;
  logic        o_ras_empty;
  logic        o_ras_full;

  pc_gen #(
    .WIDTH    (32),
    .RESET_VEC(32'h0000_0000),
    .TRAP_VEC (32'h0000_0100),
    .RAS_DEPTH(4)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .i_stall       (i_stall),
    .i_redirect    (i_redirect),
    .i_redirect_tgt(i_redirect_tgt),
    .i_trap        (i_trap),
    .i_call        (i_call),
    .i_ret         (i_ret),
    .o_pc          (o_pc),
    .o_pc_valid    (o_pc_valid),
    .o_misaligned  (o_misaligned),
    .o_bad_addr    (o_bad_addr),
    .o_ras_empty   (o_ras_empty),
    .o_ras_full    (o_ras_full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  // Reference model: architectural PC plus the RAS as a bounded queue
  // (back = most recent call, front = oldest).
  logic [31:0] m_pc;
  logic        m_valid;
  logic        m_mis;
  logic [31:0] m_bad;
  logic [31:0] m_ras[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc    = 32'h0;
    m_valid = 1'b0;
    m_mis   = 1'b0;
    m_bad   = 32'h0;
    m_ras.delete();
  endtask

  task automatic check_all(input string tag);
    check({tag, ".pc"},    o_pc,                 m_pc);
    check({tag, ".valid"}, 32'(o_pc_valid),      32'(m_valid));
    check({tag, ".mis"},   32'(o_misaligned),    32'(m_mis));
    check({tag, ".bad"},   o_bad_addr,           m_bad);
    check({tag, ".empty"}, 32'(o_ras_empty),     32'(m_ras.size() == 0));
    check({tag, ".full"},  32'(o_ras_full),      32'(m_ras.size() == DEPTH));
  endtask

  // Drive one cycle of inputs, advance the model, clock the DUT, compare.
  task automatic step(input string tag, input bit stall, input bit redir,
                      input logic [31:0] tgt, input bit trap, input bit call, input bit ret);
    logic [31:0] n_pc;
    logic        n_mis;
    logic [31:0] n_bad;
    logic [31:0] q[$];
    i_stall        = stall;
    i_redirect     = redir;
    i_redirect_tgt = tgt;
    i_trap         = trap;
    i_call         = call;
    i_ret          = ret;

    q     = m_ras;
    n_pc  = m_pc + 32'd4;
    n_mis = 1'b0;
    n_bad = m_bad;
    if (trap) begin
      n_pc = TRAP;
      q.delete();
    end else if (redir && (tgt % 4 != 0)) begin
      n_pc  = TRAP;
      n_mis = 1'b1;
      n_bad = tgt;
      q.delete();
    end else if (redir) begin
      n_pc = tgt;
    end else if (stall) begin
      n_pc = m_pc;
    end else if (ret && q.size() > 0) begin
      n_pc = q.pop_back();
      if (call) q.push_back(m_pc + 32'd4);
    end else if (call) begin
      q.push_back(m_pc + 32'd4);
      if (q.size() > DEPTH) void'(q.pop_front());
    end

    @(posedge clk);
    #1;
    m_pc    = n_pc;
    m_valid = 1'b1;
    m_mis   = n_mis;
    m_bad   = n_bad;
    m_ras   = q;
    check_all(tag);
  endtask

  task automatic free(input string tag);
    step(tag, 0, 0, 32'h0, 0, 0, 0);
  endtask

  task automatic jump(input logic [31:0] tgt);
    step("jump", 0, 1, tgt, 0, 0, 0);
  endtask

  initial begin
    rst = 1'b0;
    i_stall = 0; i_redirect = 0; i_redirect_tgt = '0; i_trap = 0; i_call = 0; i_ret = 0;
    model_reset();
    #1;
    check_all("reset");
    #6 rst = 1'b1;

    // Free-running after reset release.
    free("run0"); check("run0.const", o_pc, 32'h4);
    free("run1"); check("run1.const", o_pc, 32'h8);
    free("run2"); check("run2.const", o_pc, 32'hC);
    free("run3"); check("run3.const", o_pc, 32'h10);

    // Stall, then redirect while still stalled.
    for (int i = 0; i < 3; i++) begin
      step("stall", 1, 0, 32'h0, 0, 1, 1);
      check("stall.const", o_pc, 32'h10);
    end
    step("redir_stall", 1, 1, 32'h200, 0, 0, 0);
    check("redir_stall.const", o_pc, 32'h200);
    free("after_stall"); check("after_stall.const", o_pc, 32'h204);

    // Misaligned redirect.
    step("misalign", 0, 1, 32'h202, 0, 0, 0);
    check("misalign.pc", o_pc, 32'h100);
    check("misalign.pulse", 32'(o_misaligned), 32'd1);
    check("misalign.bad", o_bad_addr, 32'h202);
    free("misalign_post");
    check("misalign.drop", 32'(o_misaligned), 32'd0);
    check("misalign.hold", o_bad_addr, 32'h202);

    // RAS overflow: five calls into a four-entry stack, then five returns.
    for (int i = 0; i < 5; i++) begin
      jump(32'(i) * 32'h10);
      step("call", 0, 0, 32'h0, 0, 1, 0);
      if (i == 3) check("ras.full4", 32'(o_ras_full), 32'd1);
    end
    step("ret1", 0, 0, 32'h0, 0, 0, 1); check("ret1.const", o_pc, 32'h44);
    step("ret2", 0, 0, 32'h0, 0, 0, 1); check("ret2.const", o_pc, 32'h34);
    step("ret3", 0, 0, 32'h0, 0, 0, 1); check("ret3.const", o_pc, 32'h24);
    step("ret4", 0, 0, 32'h0, 0, 0, 1); check("ret4.const", o_pc, 32'h14);
    step("ret5", 0, 0, 32'h0, 0, 0, 1); check("ret5.const", o_pc, 32'h18);

    // Call+ret together on empty and non-empty stacks.
    step("cr_empty", 0, 0, 32'h0, 0, 1, 1);
    check("cr_empty.const", o_pc, 32'h1C);
    step("cr_full", 0, 0, 32'h0, 0, 1, 1);
    check("cr_full.const", o_pc, 32'h1C);

    // Trap beats redirect and call; then wrap-around.
    step("call_pre", 0, 0, 32'h0, 0, 1, 0);
    step("trap_all", 0, 1, 32'h300, 1, 1, 0);
    check("trap_all.pc", o_pc, 32'h100);
    check("trap_all.empty", 32'(o_ras_empty), 32'd1);
    jump(32'hFFFF_FFFC);
    free("wrap"); check("wrap.const", o_pc, 32'h0);

    // Asynchronous reset with two RAS entries live.
    step("call_a", 0, 0, 32'h0, 0, 1, 0);
    step("call_b", 0, 0, 32'h0, 0, 1, 0);
    #2 rst = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    #2 rst = 1'b1;
    free("post_rst"); check("post_rst.const", o_pc, 32'h4);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      logic [31:0] tgt;
      bit st, rd, tr, ca, re;
      tgt = $urandom_range(0, 255) << 2;
      if ($urandom_range(0, 7) == 0) tgt = tgt | 32'($urandom_range(1, 3));
      if ($urandom_range(0, 31) == 0) tgt = 32'hFFFF_FFF8;
      st = ($urandom_range(0, 4) == 0);
      rd = ($urandom_range(0, 9) == 0);
      tr = ($urandom_range(0, 39) == 0);
      ca = ($urandom_range(0, 2) == 0);
      re = ($urandom_range(0, 2) == 0);
      step("rand", st, rd, tgt, tr, ca, re);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_gen.md
Name: pc_gen

Overview:
- Parametrised fetch-address generator for the RV32I front end; next generation of the plain incrementing PC.
- Adds a configurable reset vector, stall, execute-stage redirect, trap vectoring, misaligned-target detection and a small return-address stack (RAS) for call/return prediction.
- Sits between the hazard/branch units and instruction memory; o_pc drives the imem address.

Parameters:
- WIDTH, 32, PC width in bits.
- RESET_VEC, 32'h0000_0000, PC value loaded during reset.
- TRAP_VEC, 32'h0000_0100, PC loaded on trap or misaligned redirect.
- RAS_DEPTH, 4, number of RAS entries (power of two, ≥2).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- i_stall  in  1  hold PC (hazard stall).
- i_redirect  in  1  execute-stage branch/jump redirect valid.
- i_redirect_tgt  in  WIDTH  redirect target address.
- i_trap  in  1  exception/interrupt; vector to TRAP_VEC.
- i_call  in  1  predecoded call at current o_pc; push o_pc+4.
- i_ret  in  1  predecoded return at current o_pc; pop RAS as next PC.
- o_pc  out  WIDTH  current fetch address.
- o_pc_valid  out  1  o_pc is a legal fetch address.
- o_misaligned  out  1  one-cycle pulse: redirect target not 4-byte aligned.
- o_bad_addr  out  WIDTH  offending target, valid when o_misaligned=1.
- o_ras_empty  out  1  RAS count == 0.
- o_ras_full  out  1  RAS count == RAS_DEPTH.

Behaviour:
- Reset (rst=0, async): o_pc=RESET_VEC, o_pc_valid=0, o_misaligned=0, o_bad_addr=0, RAS count=0, top pointer=0, o_ras_empty=1, o_ras_full=0.
- First rising edge after rst deasserts: o_pc_valid→1, stays 1. PC update on that same edge follows normal priority.
- All updates registered; next-PC takes effect one edge after inputs are sampled.
- Next-PC priority, highest first:
  1. i_trap → TRAP_VEC; RAS cleared (count=0).
  2. i_redirect with i_redirect_tgt[1:0]!=0 → TRAP_VEC; o_misaligned=1 next cycle; o_bad_addr=i_redirect_tgt; RAS cleared.
  3. i_redirect aligned → i_redirect_tgt; RAS unchanged.
  4. i_stall → o_pc held; i_call/i_ret ignored.
  5. i_ret with RAS non-empty → popped top entry.
  6. otherwise → o_pc+4.
- Trap and redirect override stall.
- i_call/i_ret are ignored whenever rows 1–4 apply.
- Sequential increment wraps modulo 2^WIDTH: 0xFFFF_FFFC→0x0000_0000, no flag.
- o_misaligned is a single-cycle pulse. o_bad_addr holds its last value until the next misalign.
- RAS is a circular LIFO of RAS_DEPTH×WIDTH registers.
  - Push writes o_pc+4 at the top; count saturates at RAS_DEPTH.
  - Overflow silently overwrites the oldest entry.
- i_ret with RAS empty: no pop; next PC = o_pc+4; count stays 0.
- i_call and i_ret together with RAS non-empty:
  - next PC = popped top;
  - o_pc+4 is written into the vacated slot;
  - count unchanged.
- i_call and i_ret together with RAS empty: next PC = o_pc+4; push o_pc+4; count=1.
- Reset asserted mid-operation: all state returns to reset values immediately (asynchronous), independent of the clock.
- Implementation is fully synchronous apart from the reset.

Test Plan:
- Reset release, RESET_VEC=0x0, 4 free-running cycles → o_pc 0x0, 0x4, 0x8, 0xC; o_pc_valid=0 before the first edge, 1 after.
- At o_pc=0x10: i_stall for 3 cycles, then i_redirect=1 with tgt=0x200 while still stalled → o_pc holds 0x10 for 3 cycles, then 0x200, then 0x204 after the stall drops.
- Misaligned redirect tgt=0x202 → o_pc=0x100, o_misaligned high exactly one cycle, o_bad_addr=0x202, o_ras_empty=1.
- RAS overflow (RAS_DEPTH=4): calls at PCs 0x0, 0x10, 0x20, 0x30, 0x40, then 5 rets →
  - rets return 0x44, 0x34, 0x24, 0x14 in that order;
  - o_ras_full=1 after the 4th call;
  - 5th ret finds the RAS empty and falls through to sequential +4.
- Simultaneous i_trap + i_redirect + i_call → o_pc=0x100, RAS count=0; then o_pc=0xFFFF_FFFC free-running → wraps to 0x0.
- Assert rst asynchronously mid-cycle while the RAS holds 2 entries → o_pc=RESET_VEC before the next clock edge; o_ras_empty=1; o_pc_valid=0.
